// File: rtl/apb4_pkg.sv
// ============================================================================
// apb4_pkg : shared APB4 master-side types and response constants
// Rev 1.0
// ============================================================================
`default_nettype none

package apb4_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic PSLVERR_OKAY  = 1'b0;
  localparam logic PSLVERR_ERROR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin picker, first request at/after ptr_i
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int MASTERS = 4,
  parameter int IW      = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [MASTERS-1:0] gnt_o,
  output logic [IW-1:0]      gnt_idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    j         = 0;
    if (en_i) begin
      for (int i = 0; i < MASTERS; i++) begin
        j = int'(ptr_i) + i;
        if (j >= MASTERS) j = j - MASTERS;
        if (!any_o && req_i[IW'(j)]) begin
          any_o          = 1'b1;
          gnt_o[IW'(j)]  = 1'b1;
          gnt_idx_o      = IW'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arb.sv
// ============================================================================
// apb_master_arb : round-robin sharing of one APB4 master port, with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_master_arb
  import apb4_pkg::*;
#(
  parameter int PADDR_SIZE = 8,
  parameter int PDATA_SIZE = 8,
  parameter int MASTERS    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                                     PCLK,
  input  logic                                     PRESETn,
  input  logic [MASTERS-1:0]                       req,
  input  logic [MASTERS-1:0][PADDR_SIZE-1:0]       req_addr,
  input  logic [MASTERS-1:0]                       req_write,
  input  logic [MASTERS-1:0][PDATA_SIZE-1:0]       req_wdata,
  input  logic [MASTERS-1:0][PDATA_SIZE/8-1:0]     req_strb,
  output logic [MASTERS-1:0]                       done,
  output logic [PDATA_SIZE-1:0]                    rsp_rdata,
  output logic                                     rsp_err,
  output logic                                     PSEL,
  output logic                                     PENABLE,
  output logic [PADDR_SIZE-1:0]                    PADDR,
  output logic                                     PWRITE,
  output logic [PDATA_SIZE-1:0]                    PWDATA,
  output logic [PDATA_SIZE/8-1:0]                  PSTRB,
  input  logic [PDATA_SIZE-1:0]                    PRDATA,
  input  logic                                     PREADY,
  input  logic                                     PSLVERR
);

  localparam int IW = $clog2(MASTERS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = PDATA_SIZE / 8;

  apb_state_e              state_q;
  logic [IW-1:0]           ptr_q, gidx_q, ptr_d, arb_ptr_w, gnt_idx_w;
  logic [MASTERS-1:0]      gnt_oh_q, gnt_w, req_w, done_q;
  logic [TW-1:0]           tcnt_q;
  logic                    psel_q, penable_q, pwrite_q, rsp_err_q;
  logic [PADDR_SIZE-1:0]   paddr_q;
  logic [PDATA_SIZE-1:0]   pwdata_q, rsp_rdata_q;
  logic [SW-1:0]           pstrb_q;
  logic                    any_w, timeout_w, complete_w, arb_en_w;

  // tcnt_q counts ACCESS cycles already spent, so the TIMEOUT-th one expires
  assign timeout_w  = (TIMEOUT != 0) && (int'(tcnt_q) >= TIMEOUT - 1);
  assign complete_w = (state_q == ACCESS) && (PREADY || timeout_w);
  assign arb_en_w   = (state_q == IDLE) || complete_w;
  assign ptr_d      = (gidx_q == IW'(MASTERS - 1)) ? '0 : gidx_q + 1'b1;
  assign arb_ptr_w  = (state_q == IDLE) ? ptr_q : ptr_d;
  // The requester finishing this cycle must not win the back-to-back slot
  assign req_w      = (state_q == ACCESS) ? (req & ~gnt_oh_q) : req;

  rr_arbiter #(
    .MASTERS (MASTERS),
    .IW      (IW)
  ) u_arb (
    .req_i     (req_w),
    .ptr_i     (arb_ptr_w),
    .en_i      (arb_en_w),
    .gnt_o     (gnt_w),
    .gnt_idx_o (gnt_idx_w),
    .any_o     (any_w)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      gnt_oh_q    <= '0;
      tcnt_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= PSLVERR_OKAY;
    end else begin
      done_q <= '0;
      if (arb_en_w && any_w) begin
        gidx_q   <= gnt_idx_w;
        gnt_oh_q <= gnt_w;
        paddr_q  <= req_addr[gnt_idx_w];
        pwrite_q <= req_write[gnt_idx_w];
        pwdata_q <= req_wdata[gnt_idx_w];
        pstrb_q  <= req_strb[gnt_idx_w];
      end
      case (state_q)
        IDLE: begin
          if (any_w) begin
            state_q <= SETUP;
            psel_q  <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          tcnt_q    <= '0;
        end
        ACCESS: begin
          if (tcnt_q != {TW{1'b1}}) tcnt_q <= tcnt_q + 1'b1;
          if (complete_w) begin
            done_q      <= gnt_oh_q;
            ptr_q       <= ptr_d;
            penable_q   <= 1'b0;
            rsp_err_q   <= PREADY ? PSLVERR : PSLVERR_ERROR;
            rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
            if (any_w) begin
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign done      = done_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

`default_nettype wire
